// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch FSM encoding, instruction and
// program-memory geometry, and small elaboration-time helpers.
package mips_pkg;

    localparam int unsigned LONG_INSTRUCCION         = 32;
    localparam int unsigned ADDR_MEM_PROGRAMA_LENGTH = 11;
    localparam logic [LONG_INSTRUCCION-1:0] HALT_OPCODE = '0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    // Pointer width for a circular buffer; a single-entry buffer still needs one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_fetch.sv
// Synchronous FIFO used as the fetch-stage output buffer; flush empties it in
// one cycle and takes precedence over push/pop.
module fifo_fetch #(
    parameter int WIDTH = 43,
    parameter int DEPTH = 3,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    import mips_pkg::*;

    localparam int PTR_W = ptr_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/etapa_fetch.sv
// MIPS instruction-fetch stage: issues program-memory reads, tracks them through
// the memory latency and presents {instruction, PC+1} to IF/ID with valid/stall.
module etapa_fetch #(
    parameter int ADDR_LENGTH      = mips_pkg::ADDR_MEM_PROGRAMA_LENGTH,
    parameter int LONG_INSTRUCCION = mips_pkg::LONG_INSTRUCCION,
    parameter logic [LONG_INSTRUCCION-1:0] HALT_OPCODE = LONG_INSTRUCCION'(mips_pkg::HALT_OPCODE),
    parameter int MEM_LATENCY      = 2
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_soft_reset,
    input  logic                        i_enable,
    input  logic                        i_modo_ejecucion,
    input  logic                        i_step,
    input  logic                        i_stall,
    input  logic                        i_redirect,
    input  logic [ADDR_LENGTH-1:0]      i_redirect_addr,
    input  logic [LONG_INSTRUCCION-1:0] i_instruccion,
    output logic [ADDR_LENGTH-1:0]      o_addr_mem_programa,
    output logic [LONG_INSTRUCCION-1:0] o_instruccion,
    output logic [ADDR_LENGTH-1:0]      o_pc_next,
    output logic                        o_valid,
    output logic                        o_halt,
    output logic                        o_soft_reset_ack
);
    import mips_pkg::*;

    localparam int BUF_DEPTH = MEM_LATENCY + 1;
    localparam int BUF_CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int OCC_W     = $clog2(2 * MEM_LATENCY + 2);
    localparam int BUF_W     = LONG_INSTRUCCION + ADDR_LENGTH;

    fetch_state_t state;
    fetch_state_t state_next;

    logic [ADDR_LENGTH-1:0] pc;
    logic [MEM_LATENCY-1:0] fly_valid;
    logic [ADDR_LENGTH-1:0] fly_pc [MEM_LATENCY];
    logic [OCC_W-1:0]       fly_count;
    logic [OCC_W-1:0]       occupancy;

    logic                   step_credit;
    logic                   halt_flag;
    logic                   ack_flag;

    logic                   buf_full;
    logic                   buf_empty;
    logic [BUF_CNT_W-1:0]   buf_count;
    logic [BUF_W-1:0]       buf_head;
    logic                   buf_push;

    logic                   transfer;
    logic                   halt_transfer;
    logic                   flush;
    logic                   issue;

    assign o_addr_mem_programa = pc;
    assign o_halt              = halt_flag;
    assign o_soft_reset_ack    = ack_flag;
    assign o_instruccion       = buf_head[BUF_W-1:ADDR_LENGTH];
    assign o_pc_next           = buf_head[ADDR_LENGTH-1:0];

    assign o_valid       = !buf_empty && (state != HALTED) && (!i_modo_ejecucion || step_credit);
    assign transfer      = o_valid && !i_stall;
    assign halt_transfer = transfer && (o_instruccion == HALT_OPCODE);
    assign flush         = i_soft_reset || halt_transfer || i_redirect;

    always_comb begin
        fly_count = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            fly_count = fly_count + OCC_W'(fly_valid[i]);
        end
    end

    // The entry leaving the buffer this cycle frees its slot immediately, which
    // keeps the loop at one issue per cycle while never overfilling the buffer.
    assign occupancy = fly_count + OCC_W'(buf_count) - OCC_W'(transfer);
    assign issue     = (state == RUN) && !flush && (occupancy < OCC_W'(BUF_DEPTH));
    assign buf_push  = fly_valid[MEM_LATENCY-1] && !flush && (!buf_full || transfer);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (i_enable) state_next = RUN;
            RUN:     if (halt_transfer) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = IDLE;
        endcase
        if (i_soft_reset) begin
            state_next = IDLE;
        end
    end

    // In-flight shift line: slot 0 holds the address issued last cycle and the
    // last slot lines up with the data the memory returns this cycle.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            pc        <= '0;
            fly_valid <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) begin
                fly_pc[i] <= '0;
            end
        end else if (i_soft_reset) begin
            pc        <= '0;
            fly_valid <= '0;
        end else if (halt_transfer) begin
            fly_valid <= '0;
        end else if (i_redirect) begin
            fly_valid <= '0;
            pc        <= i_redirect_addr;
        end else begin
            fly_valid[0] <= issue;
            fly_pc[0]    <= pc;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                fly_valid[i] <= fly_valid[i-1];
                fly_pc[i]    <= fly_pc[i-1];
            end
            if (issue) begin
                pc <= pc + ADDR_LENGTH'(1);
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            halt_flag   <= 1'b0;
            step_credit <= 1'b0;
            ack_flag    <= 1'b0;
        end else begin
            ack_flag <= i_soft_reset;
            if (i_soft_reset) begin
                halt_flag   <= 1'b0;
                step_credit <= 1'b0;
            end else begin
                if (halt_transfer) begin
                    halt_flag <= 1'b1;
                end
                if (transfer) begin
                    step_credit <= 1'b0;
                end else if (i_step) begin
                    step_credit <= 1'b1;
                end
            end
        end
    end

    fifo_fetch #(
        .WIDTH (BUF_W),
        .DEPTH (BUF_DEPTH),
        .CNT_W (BUF_CNT_W)
    ) u_fifo_fetch (
        .clock   (i_clock),
        .reset   (i_reset),
        .flush   (flush),
        .push    (buf_push),
        .pop     (transfer),
        .wr_data ({i_instruccion, fly_pc[MEM_LATENCY-1] + ADDR_LENGTH'(1)}),
        .rd_data (buf_head),
        .full    (buf_full),
        .empty   (buf_empty),
        .count   (buf_count)
    );

endmodule

// File: tb/tb_etapa_fetch.sv
// Directed bench for etapa_fetch against a two-cycle registered program memory
// whose word at address a is 0x20010001 + a (optionally HALT at address 5).
module tb_etapa_fetch;

    logic        clock;
    logic        i_reset;
    logic        i_soft_reset;
    logic        i_enable;
    logic        i_modo_ejecucion;
    logic        i_step;
    logic        i_stall;
    logic        i_redirect;
    logic [10:0] i_redirect_addr;
    logic [31:0] i_instruccion;
    logic [10:0] o_addr_mem_programa;
    logic [31:0] o_instruccion;
    logic [10:0] o_pc_next;
    logic        o_valid;
    logic        o_halt;
    logic        o_soft_reset_ack;

    logic        halt_at_5;
    logic [31:0] mem_q1;
    logic [31:0] mem_q2;

    int checks;
    int failures;
    int xfer_count;

    etapa_fetch #(
        .ADDR_LENGTH      (11),
        .LONG_INSTRUCCION (32),
        .HALT_OPCODE      (32'h0),
        .MEM_LATENCY      (2)
    ) dut (
        .i_clock             (clock),
        .i_reset             (i_reset),
        .i_soft_reset        (i_soft_reset),
        .i_enable            (i_enable),
        .i_modo_ejecucion    (i_modo_ejecucion),
        .i_step              (i_step),
        .i_stall             (i_stall),
        .i_redirect          (i_redirect),
        .i_redirect_addr     (i_redirect_addr),
        .i_instruccion       (i_instruccion),
        .o_addr_mem_programa (o_addr_mem_programa),
        .o_instruccion       (o_instruccion),
        .o_pc_next           (o_pc_next),
        .o_valid             (o_valid),
        .o_halt              (o_halt),
        .o_soft_reset_ack    (o_soft_reset_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [10:0] a, input logic halt_en);
        if (halt_en && (a == 11'd5)) return 32'h0;
        return 32'h20010001 + {21'd0, a};
    endfunction

    // Program memory with a registered two-cycle read.
    always @(posedge clock) begin
        mem_q1 <= mem_word(o_addr_mem_programa, halt_at_5);
        mem_q2 <= mem_q1;
    end
    assign i_instruccion = mem_q2;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance n cycles, counting transfers; leaves time at posedge+1.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            if (o_valid && !i_stall) xfer_count++;
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        checks = 0; failures = 0; xfer_count = 0;
        halt_at_5 = 1'b0;
        i_reset = 1'b1; i_soft_reset = 1'b0; i_enable = 1'b0; i_modo_ejecucion = 1'b0;
        i_step = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_addr = '0;
        applyStimulus(2);
        checkOutput("reset_addr",  32'(o_addr_mem_programa), 32'h0);
        checkOutput("reset_instr", o_instruccion, 32'h0);
        checkOutput("reset_pcn",   32'(o_pc_next), 32'h0);
        checkOutput("reset_valid", 32'(o_valid), 32'h0);
        checkOutput("reset_halt",  32'(o_halt), 32'h0);
        checkOutput("reset_ack",   32'(o_soft_reset_ack), 32'h0);
        i_reset = 1'b0;
        applyStimulus(2);
        checkOutput("idle_no_issue", 32'(o_addr_mem_programa), 32'h0);

        // First fetch: address 0 in C1, valid in C4.
        i_enable = 1'b1;
        applyStimulus(1);
        checkOutput("c1_addr", 32'(o_addr_mem_programa), 32'h0);
        checkOutput("c1_valid", 32'(o_valid), 32'h0);
        applyStimulus(1);
        checkOutput("c2_addr", 32'(o_addr_mem_programa), 32'h1);
        checkOutput("c2_valid", 32'(o_valid), 32'h0);
        applyStimulus(1);
        checkOutput("c3_valid", 32'(o_valid), 32'h0);
        applyStimulus(1);
        checkOutput("c4_valid", 32'(o_valid), 32'h1);
        checkOutput("c4_instr", o_instruccion, 32'h20010001);
        checkOutput("c4_pcn",   32'(o_pc_next), 32'h1);
        applyStimulus(1);
        checkOutput("c5_pcn",   32'(o_pc_next), 32'h2);
        checkOutput("c5_instr", o_instruccion, 32'h20010002);
        applyStimulus(1);

        // Ten-cycle stall: three outstanding, issue frozen at address 5.
        i_stall = 1'b1;
        checkOutput("stall_addr_first", 32'(o_addr_mem_programa), 32'h5);
        checkOutput("stall_pcn_first",  32'(o_pc_next), 32'h3);
        applyStimulus(9);
        checkOutput("stall_addr_last",  32'(o_addr_mem_programa), 32'h5);
        checkOutput("stall_pcn_last",   32'(o_pc_next), 32'h3);
        checkOutput("stall_valid_last", 32'(o_valid), 32'h1);
        applyStimulus(1);
        i_stall = 1'b0;
        for (int k = 0; k < 5; k++) begin
            checkOutput("resume_valid", 32'(o_valid), 32'h1);
            checkOutput("resume_pcn",   32'(o_pc_next), 32'(3 + k));
            checkOutput("resume_instr", o_instruccion, 32'h20010003 + 32'(k));
            applyStimulus(1);
        end

        // Redirect to 0x100 with two fetches in flight.
        i_redirect = 1'b1; i_redirect_addr = 11'h100;
        applyStimulus(1);
        i_redirect = 1'b0;
        checkOutput("redir_addr", 32'(o_addr_mem_programa), 32'h100);
        checkOutput("redir_squash1", 32'(o_valid), 32'h0);
        applyStimulus(1);
        checkOutput("redir_squash2", 32'(o_valid), 32'h0);
        applyStimulus(1);
        checkOutput("redir_squash3", 32'(o_valid), 32'h0);
        applyStimulus(1);
        checkOutput("redir_valid", 32'(o_valid), 32'h1);
        checkOutput("redir_pcn",   32'(o_pc_next), 32'h101);
        checkOutput("redir_instr", o_instruccion, 32'h20010101);

        // PC wrap from 0x7FF to 0x000.
        i_redirect = 1'b1; i_redirect_addr = 11'h7FF;
        applyStimulus(1);
        i_redirect = 1'b0;
        checkOutput("wrap_addr_top", 32'(o_addr_mem_programa), 32'h7FF);
        applyStimulus(1);
        checkOutput("wrap_addr_zero", 32'(o_addr_mem_programa), 32'h0);
        applyStimulus(2);
        checkOutput("wrap_pcn_top",   32'(o_pc_next), 32'h0);
        checkOutput("wrap_instr_top", o_instruccion, 32'h20010800);
        applyStimulus(1);
        checkOutput("wrap_pcn_next",  32'(o_pc_next), 32'h1);

        // HALT word at address 5.
        halt_at_5 = 1'b1;
        i_redirect = 1'b1; i_redirect_addr = 11'h0;
        applyStimulus(1);
        i_redirect = 1'b0;
        applyStimulus(3);
        for (int k = 0; k < 5; k++) begin
            checkOutput("prehalt_valid", 32'(o_valid), 32'h1);
            checkOutput("prehalt_pcn",   32'(o_pc_next), 32'(1 + k));
            applyStimulus(1);
        end
        checkOutput("halt_word_instr", o_instruccion, 32'h0);
        checkOutput("halt_word_pcn",   32'(o_pc_next), 32'h6);
        checkOutput("halt_word_valid", 32'(o_valid), 32'h1);
        checkOutput("halt_word_flag",  32'(o_halt), 32'h0);
        applyStimulus(1);
        checkOutput("halted_flag",  32'(o_halt), 32'h1);
        checkOutput("halted_valid", 32'(o_valid), 32'h0);
        applyStimulus(2);
        checkOutput("halted_flag_sticky", 32'(o_halt), 32'h1);
        checkOutput("halted_valid_low",   32'(o_valid), 32'h0);
        checkOutput("halted_addr_frozen", 32'(o_addr_mem_programa), 32'h8);

        // Soft reset restarts from PC 0.
        halt_at_5 = 1'b0;
        i_soft_reset = 1'b1;
        applyStimulus(1);
        i_soft_reset = 1'b0;
        checkOutput("srst_halt",  32'(o_halt), 32'h0);
        checkOutput("srst_ack",   32'(o_soft_reset_ack), 32'h1);
        checkOutput("srst_addr",  32'(o_addr_mem_programa), 32'h0);
        checkOutput("srst_valid", 32'(o_valid), 32'h0);
        applyStimulus(1);
        checkOutput("srst_ack_pulse", 32'(o_soft_reset_ack), 32'h0);
        checkOutput("srst_addr_run",  32'(o_addr_mem_programa), 32'h0);
        applyStimulus(1);
        checkOutput("srst_addr_next", 32'(o_addr_mem_programa), 32'h1);
        applyStimulus(2);
        checkOutput("srst_first_valid", 32'(o_valid), 32'h1);
        checkOutput("srst_first_pcn",   32'(o_pc_next), 32'h1);

        // Step mode: three spaced pulses give three transfers.
        i_modo_ejecucion = 1'b1;
        #1;
        checkOutput("step_no_credit", 32'(o_valid), 32'h0);
        xfer_count = 0;
        for (int p = 0; p < 3; p++) begin
            i_step = 1'b1;
            applyStimulus(1);
            i_step = 1'b0;
            applyStimulus(19);
            checkOutput("step_credit_used", 32'(o_valid), 32'h0);
        end
        checkOutput("step_xfers", 32'(xfer_count), 32'h3);
        checkOutput("step_head_pcn", 32'(o_pc_next), 32'h4);

        // Two pulses before the transfer can happen yield one transfer.
        i_stall = 1'b1;
        i_step = 1'b1; applyStimulus(1);
        i_step = 1'b0; applyStimulus(1);
        checkOutput("dbl_valid_stalled", 32'(o_valid), 32'h1);
        i_step = 1'b1; applyStimulus(1);
        i_step = 1'b0; applyStimulus(2);
        i_stall = 1'b0;
        applyStimulus(20);
        checkOutput("dbl_xfers", 32'(xfer_count), 32'h4);
        checkOutput("dbl_head_pcn", 32'(o_pc_next), 32'h5);
        checkOutput("dbl_valid_low", 32'(o_valid), 32'h0);

        // Asynchronous reset mid-fetch.
        i_modo_ejecucion = 1'b0;
        applyStimulus(6);
        checkOutput("pre_areset_valid", 32'(o_valid), 32'h1);
        #2;
        i_reset = 1'b1;
        #1;
        checkOutput("areset_addr",  32'(o_addr_mem_programa), 32'h0);
        checkOutput("areset_instr", o_instruccion, 32'h0);
        checkOutput("areset_pcn",   32'(o_pc_next), 32'h0);
        checkOutput("areset_valid", 32'(o_valid), 32'h0);
        checkOutput("areset_halt",  32'(o_halt), 32'h0);
        checkOutput("areset_ack",   32'(o_soft_reset_ack), 32'h0);
        applyStimulus(2);
        i_reset = 1'b0;
        applyStimulus(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
